bus_transfer_sequencer: RTL and testbench
=========================================

// Module: bus_transfer_sequencer
// PURPOSE
//   Upstream driver of the 32-to-1 bus multiplexer. Accepts one register-transfer request
//   (source code, destination load mask) over a valid/ready handshake. Drives the mux
//   select_signal, holds it for a settle interval, then pulses the destination load enables.
//   Flags malformed requests. Sits between the control unit and the bus mux / register enables.
// PARAMETERS
//   NUM_SRC        27  highest legal source code (1=R0..16=R15,17=HI,18=LO,19=Zhigh,20=Zlow,
//                      21=PC,22=MDR,23=InPort,24=C_sign_ext,25=Y,26=IR,27=MAR); 0 = bus idle
//   DST_W          24  width of destination load-enable mask (one bit per loadable register)
//   SETTLE_CYCLES  1   cycles select is held before load pulse; legal range 1..15
// PORTS
//   clock          in   1      rising-edge clock
//   reset          in   1      synchronous, active-high
//   req_valid      in   1      transfer request present
//   req_ready      out  1      sequencer can accept a request this cycle
//   req_src        in   5      source code, encoding as NUM_SRC above
//   req_dst        in   DST_W  destination load mask; multi-hot allowed
//   select_signal  out  5      to bus mux select; 0 when no transfer active
//   load_en        out  DST_W  destination register load enables
//   done           out  1      1-cycle pulse, coincident with load_en
//   err            out  1      1-cycle pulse on rejected request
// BEHAVIOUR
//   Reset (reset=1 at an edge): state=IDLE, select_signal=0, load_en=0, done=0, err=0.
//     req_ready=0 while reset is high.
//   FSM states IDLE, SETTLE, LOAD. All outputs are registered except req_ready.
//     req_ready = (state==IDLE) && !reset.
//   IDLE: select_signal=0, load_en=0. Accept occurs when req_valid && req_ready at an edge.
//     Legal request: req_src in 1..NUM_SRC and req_dst != 0. Capture src/dst.
//       Load settle counter with SETTLE_CYCLES-1. Go to SETTLE.
//     Illegal request (src==0, src>NUM_SRC, or dst==0): err=1 for the next cycle only.
//       Stay IDLE. No select and no load.
//   SETTLE: select_signal=captured src, load_en=0. Counter decrements each cycle.
//     At counter==0 go to LOAD.
//   LOAD (exactly 1 cycle): select_signal=src, load_en=captured dst, done=1. Then go to IDLE.
//   Cycle timing, accept at edge T:
//     T+1..T+SETTLE_CYCLES = SETTLE.
//     T+SETTLE_CYCLES+1 = LOAD.
//     Next cycle = IDLE with select_signal=0.
//   Throughput: minimum request-to-request period is SETTLE_CYCLES+2. select_signal returns
//     to 0 for at least one cycle between transfers.
//   req_src/req_dst are ignored outside the accept edge. Changing them mid-transfer has no effect.
//   Source register may appear in the destination mask (e.g. R1->R1). This is legal and needs
//     no special handling.
//   Reset during SETTLE or LOAD aborts the transfer. From the next cycle all outputs are 0.
//     load_en of an aborted transfer never asserts after the reset edge.
//   done and err are never high in the same cycle.
// TESTING
//   1 Reset held 2 cycles, then released: all outputs 0 and req_ready=0 during reset;
//     req_ready=1 on the first cycle after release.
//   2 SETTLE_CYCLES=1, src=2 (R1), dst=1<<5, accepted at edge 0:
//     cyc1: sel=2, load=0.
//     cyc2: sel=2, load=0x20, done=1.
//     cyc3: sel=0, ready=1.
//   3 src=0, dst=1 -> err=1 at cyc1, sel=0, load=0, ready=1.
//     Repeat with src=28 -> err again.
//     Repeat with src=5, dst=0 -> err again.
//   4 req_valid held high with two legal requests (src 22, then 21): second accepted at edge 3;
//     sel=0 exactly at cyc3; second done at cyc5.
//   5 SETTLE_CYCLES=3, reset asserted at cyc2 (mid-SETTLE): load_en and done stay 0 throughout;
//     sel=0 from cyc3.
//   6 src=22 (MDR), dst=0x030003 -> load_en=0x030003 for exactly one cycle with done=1.

Source files
------------

// File: rtl/bus_transfer_sequencer.sv
// Bus transfer sequencer: accepts one source/destination request, drives the bus mux select,
// holds it for a settle interval, then pulses the destination load enables for one cycle.
module bus_transfer_sequencer #(
  parameter int unsigned NUM_SRC       = 27,
  parameter int unsigned DST_W         = 24,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_src,
  input  logic [DST_W-1:0] req_dst,
  output logic [4:0]       select_signal,
  output logic [DST_W-1:0] load_en,
  output logic             done,
  output logic             err
);

  localparam int unsigned SRC_W = 5;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOAD   = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [SRC_W-1:0] src_q, src_next;
  logic [DST_W-1:0] dst_q, dst_next;
  logic [SRC_W-1:0] sel_next;
  logic [DST_W-1:0] load_next;
  logic             done_next;
  logic             err_next;
  logic             accept;
  logic             legal;

  // Ready is the only combinational output; it drops immediately while reset is applied.
  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign legal     = (req_src != '0) && (32'(req_src) <= NUM_SRC) && (req_dst != '0);

  // State, captured request and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      src_q         <= '0;
      dst_q         <= '0;
      select_signal <= '0;
      load_en       <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      src_q         <= src_next;
      dst_q         <= dst_next;
      select_signal <= sel_next;
      load_en       <= load_next;
      done          <= done_next;
      err           <= err_next;
    end
  end

  // Next state and next registered output values; outputs follow the state being entered.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    src_next   = src_q;
    dst_next   = dst_q;
    sel_next   = '0;
    load_next  = '0;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (legal) begin
            src_next   = req_src;
            dst_next   = req_dst;
            cnt_next   = CNT_INIT;
            sel_next   = req_src;
            state_next = SETTLE;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      SETTLE: begin
        sel_next = src_q;
        if (cnt == '0) begin
          load_next  = dst_q;
          done_next  = 1'b1;
          state_next = LOAD;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      LOAD: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Scoreboard bench for bus_transfer_sequencer: two instances (settle 1 and settle 3) driven
// with directed then random requests; a transaction-level model predicts pulses and select.
module tb_bus_transfer_sequencer;

  localparam int unsigned NUM_SRC = 27;
  localparam int unsigned DST_W   = 24;
  localparam int unsigned NI      = 2;
  localparam int          N_CYC   = 700;
  localparam int          DIR_END = 40;

  typedef struct {
    bit              is_err;
    logic [DST_W-1:0] load;
    int              at;
  } exp_t;

  typedef struct {
    logic [4:0]       src;
    logic [DST_W-1:0] dst;
  } req_t;

  logic             clock = 1'b0;
  logic             reset         [NI];
  logic             req_valid     [NI];
  logic             req_ready     [NI];
  logic [4:0]       req_src       [NI];
  logic [DST_W-1:0] req_dst       [NI];
  logic [4:0]       select_signal [NI];
  logic [DST_W-1:0] load_en       [NI];
  logic             done          [NI];
  logic             err           [NI];

  always #5 clock = ~clock;

  bus_transfer_sequencer #(.NUM_SRC(NUM_SRC), .DST_W(DST_W), .SETTLE_CYCLES(1)) u_dut0 (
    .clock(clock), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_src(req_src[0]), .req_dst(req_dst[0]), .select_signal(select_signal[0]),
    .load_en(load_en[0]), .done(done[0]), .err(err[0])
  );

  bus_transfer_sequencer #(.NUM_SRC(NUM_SRC), .DST_W(DST_W), .SETTLE_CYCLES(3)) u_dut1 (
    .clock(clock), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_src(req_src[1]), .req_dst(req_dst[1]), .select_signal(select_signal[1]),
    .load_en(load_en[1]), .done(done[1]), .err(err[1])
  );

  int         settle   [NI] = '{1, 3};
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  bit         checking = 1'b0;
  exp_t       sb       [NI][$];
  req_t       pend     [NI][$];
  int         free_at  [NI];
  int         sel_from [NI];
  int         sel_to   [NI];
  logic [4:0] sel_src  [NI];
  bit         exp_ready[NI];
  int         abort_at [NI];
  bit         abort_armed;

  // Cycle k is the interval after the k-th rising edge.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s inst=%0d cyc=%0d actual=%h required=%h", name, i, cyc, act, req);
    end
  endtask

  function automatic bit is_legal(input req_t r);
    return (r.src >= 1) && (32'(r.src) <= NUM_SRC) && (r.dst != '0);
  endfunction

  // Drive one instance for cycle k (inputs take effect at edge k+1) and advance the model.
  task automatic drive(input int i, input bit do_rst, input bit gen);
    int   k;
    int   e;
    req_t r;
    k = cyc;
    if (gen && pend[i].size() == 0 && $urandom_range(0, 2) == 0) begin
      r.src = 5'($urandom_range(0, 31));
      r.dst = ($urandom_range(0, 7) == 0) ? '0 : DST_W'($urandom);
      pend[i].push_back(r);
    end
    if (do_rst) begin
      reset[i]     = 1'b1;
      req_valid[i] = 1'b0;
      req_src[i]   = 5'($urandom);
      req_dst[i]   = DST_W'($urandom);
      exp_ready[i] = 1'b0;
      while (sb[i].size() > 0 && sb[i][$].at > k) void'(sb[i].pop_back());
      if (sel_to[i] > k) sel_to[i] = k;
      free_at[i] = k + 1;
    end else begin
      reset[i]     = 1'b0;
      exp_ready[i] = (k >= free_at[i]);
      if (pend[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_src[i]   = pend[i][0].src;
        req_dst[i]   = pend[i][0].dst;
        if (exp_ready[i]) begin
          e = k + 1;
          r = pend[i].pop_front();
          if (is_legal(r)) begin
            sb[i].push_back('{is_err: 1'b0, load: r.dst, at: e + settle[i]});
            sel_src[i]  = r.src;
            sel_from[i] = e;
            sel_to[i]   = e + settle[i];
            free_at[i]  = e + settle[i] + 1;
            if (i == 1 && abort_armed) begin
              abort_at[1] = e + 1;
              abort_armed = 1'b0;
            end
          end else begin
            sb[i].push_back('{is_err: 1'b1, load: '0, at: e});
            free_at[i] = e;
          end
        end
      end else begin
        req_valid[i] = 1'b0;
        req_src[i]   = 5'($urandom);
        req_dst[i]   = DST_W'($urandom);
      end
    end
  endtask

  // Monitor: compare ready/select every cycle, pop the scoreboard on each done/err pulse.
  always @(negedge clock) begin
    if (checking && cyc >= 1) begin
      for (int i = 0; i < int'(NI); i++) begin
        logic [4:0] exp_sel;
        exp_t       ex;
        exp_sel = (cyc >= sel_from[i] && cyc <= sel_to[i]) ? sel_src[i] : 5'd0;
        check("ready", i, 32'(req_ready[i]), 32'(exp_ready[i]));
        check("select", i, 32'(select_signal[i]), 32'(exp_sel));
        check("done_err_excl", i, 32'(done[i] && err[i]), 32'd0);
        if (done[i] || err[i]) begin
          if (sb[i].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse inst=%0d cyc=%0d actual done=%0b err=%0b required none",
                     i, cyc, done[i], err[i]);
          end else begin
            ex = sb[i].pop_front();
            check("pulse_kind_err", i, 32'(err[i]), 32'(ex.is_err));
            check("pulse_cycle", i, 32'(cyc), 32'(ex.at));
            check("load_en", i, 32'(load_en[i]), 32'(ex.load));
          end
        end else begin
          check("load_idle", i, 32'(load_en[i]), 32'd0);
          if (sb[i].size() > 0 && sb[i][0].at <= cyc) begin
            ex = sb[i].pop_front();
            total++;
            bad++;
            $display("FAIL missing_pulse inst=%0d cyc=%0d actual none required %s at %0d",
                     i, cyc, ex.is_err ? "err" : "done", ex.at);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < int'(NI); i++) begin
      reset[i]     = 1'b1;
      req_valid[i] = 1'b0;
      req_src[i]   = '0;
      req_dst[i]   = '0;
      free_at[i]   = 0;
      sel_from[i]  = 1;
      sel_to[i]    = 0;
      sel_src[i]   = '0;
      exp_ready[i] = 1'b0;
      abort_at[i]  = -1;
    end
    abort_armed = 1'b1;
    pend[0].push_back('{src: 5'd2,  dst: 24'h000020});
    pend[0].push_back('{src: 5'd0,  dst: 24'h000001});
    pend[0].push_back('{src: 5'd28, dst: 24'h000001});
    pend[0].push_back('{src: 5'd5,  dst: 24'h000000});
    pend[0].push_back('{src: 5'd22, dst: 24'h000400});
    pend[0].push_back('{src: 5'd21, dst: 24'h800000});
    pend[0].push_back('{src: 5'd22, dst: 24'h030003});
    pend[0].push_back('{src: 5'd2,  dst: 24'h000002});
    pend[1].push_back('{src: 5'd4,  dst: 24'h000100});
    pend[1].push_back('{src: 5'd27, dst: 24'h0000F0});
    checking = 1'b1;
    for (int n = 0; n < N_CYC; n++) begin
      @(posedge clock);
      #1;
      for (int i = 0; i < int'(NI); i++) begin
        drive(i, (cyc <= 1) || (cyc == abort_at[i]) ||
                 (cyc > DIR_END && $urandom_range(0, 79) == 0),
              cyc > DIR_END);
      end
    end
    for (int i = 0; i < int'(NI); i++) pend[i].delete();
    repeat (20) begin
      @(posedge clock);
      #1;
      for (int i = 0; i < int'(NI); i++) drive(i, 1'b0, 1'b0);
    end
    @(negedge clock);
    #1;
    for (int i = 0; i < int'(NI); i++) begin
      total++;
      if (sb[i].size() != 0) begin
        bad++;
        $display("FAIL drain inst=%0d actual pending=%0d required 0", i, sb[i].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
